ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Multi-cycle RV32M divider in the EX stage, directly downstream of the ID/EX pipeline register.
//  Consumes the registered operand pair and the divide opcode when ID/EX flags a divide instruction.
//  Holds the pipeline through a stall request until the result is ready.
//  Hands a 32-bit quotient or remainder to the EX result mux, together with a one-cycle done pulse.
// PARAMETERS
//  XLEN      32  operand/result width; must be even and >= 4
//  CNT_W     6   iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  start      in   1      divide request, sampled in IDLE only
//  op         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
//  dividend   in   XLEN   rs1 value (ID/EX Anum), sampled with start
//  divisor    in   XLEN   rs2 value (ID/EX Bnum), sampled with start
//  flush      in   1      synchronous abort (branch/jump kill); priority over start
//  busy       out  1      1 when state != IDLE
//  stall_req  out  1      combinational: (IDLE & start & ~flush & ~special) | CALC
//  done       out  1      one-cycle pulse; result is valid in that cycle
//  result     out  XLEN   quotient or remainder, held until next accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  FSM: IDLE -> CALC on start&~flush&~special; IDLE -> DONE on start&~flush&special.
//       CALC -> DONE after XLEN iterations; CALC -> IDLE on flush.
//       DONE -> IDLE always, including on flush: a result already in DONE is still delivered.
//  Accept: start in cycle T (IDLE) latches op, |dividend|, |divisor|, quotient sign, remainder sign.
//  Sign handling: signed ops (DIV, REM) take two's-complement magnitudes.
//   - quotient sign = sign(dividend) XOR sign(divisor)
//   - remainder sign = sign(dividend)
//   - unsigned ops use raw values; both signs = 0.
//  Algorithm: radix-2 restoring, one quotient bit per cycle, MSB first.
//   - working remainder is XLEN+1 bits; subtract is never truncated.
//  Latency, normal case: CALC occupies T+1..T+XLEN; done=1 and result valid at T+XLEN+1.
//  Latency, special case: done=1 at T+1.
//  Special cases, detected combinationally at accept:
//   - divisor==0: quotient = all ones; remainder = dividend.
//   - DIV/REM with dividend=0x8000_0000 and divisor=all ones: quotient = 0x8000_0000; remainder = 0.
//  Final correction in DONE entry: negate quotient/remainder per latched signs, then select by op[1].
//  done is never asserted in two consecutive cycles; start is ignored while busy.
//  Flush mid-CALC: next cycle IDLE, no done pulse, result keeps its previous value.
//  start and flush in the same IDLE cycle: request dropped, stays IDLE.
//  Reset mid-operation: immediate return to reset values; no done pulse.
//  Back-to-back: a start in the cycle after done (IDLE) is accepted normally.
// TESTING
//  DIVU 100/7: start@T -> stall_req high T..T+32; done@T+33; result=14. REMU same operands -> 2.
//  DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
//  DIV x/0 with x=0x1234 -> done@T+1, result=0xFFFF_FFFF; REMU 0x1234/0 -> 0x1234.
//  DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 at T+1; REM same operands -> 0.
//  flush at T+10 of DIVU -> IDLE at T+11, no done, result unchanged; new start@T+11 completes normally.
//  rst_n low at T+5 of DIVU -> busy=0, done=0, result=0 asynchronously; start after release works.

Source files
------------

// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle RV32M divider for the EX stage.
// Radix-2 restoring divide on operand magnitudes, one quotient bit per cycle,
// with sign fix-up and quotient/remainder select when the result is registered.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a start; result holds the last delivered value
// S_CALC | iterating, one quotient bit per cycle, pipeline stalled
// S_DONE | done pulse cycle, result valid
//
// XLEN must be even and >= 4; CNT_W must satisfy 2**CNT_W > XLEN.

module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t            r_state;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dsr;
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_quo_neg;
    logic              r_rem_neg;
    logic              r_sel_rem;
    logic              r_done;

    logic              w_accept;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic              w_dvd_neg;
    logic              w_dsr_neg;
    logic [XLEN-1:0]   w_dvd_mag;
    logic [XLEN-1:0]   w_dsr_mag;
    logic [XLEN-1:0]   w_spec_result;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    // Accept qualification and the two cases that skip iteration.
    assign w_accept   = (r_state == S_IDLE) & start & ~flush;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = ~op[0] & (dividend == MIN_NEG) & (divisor == ALL_ONES);
    assign w_special  = w_div_zero | w_ovf;

    // Divide-by-zero returns the raw dividend as remainder, even for REM.
    assign w_spec_result = op[1] ? (w_div_zero ? dividend : '0)
                                 : (w_div_zero ? ALL_ONES : MIN_NEG);

    // Signed ops work on magnitudes; signs are reapplied at the end.
    assign w_dvd_neg = ~op[0] & dividend[XLEN-1];
    assign w_dsr_neg = ~op[0] & divisor[XLEN-1];
    assign w_dvd_mag = w_dvd_neg ? (-dividend) : dividend;
    assign w_dsr_mag = w_dsr_neg ? (-divisor)  : divisor;

    // One restoring step: the shifted partial remainder is XLEN+1 bits so the
    // trial subtract never loses its top bit.
    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_dsr};
    assign w_quo_next = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
    assign w_rem_next = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];

    assign w_quo_fix = r_quo_neg ? (-w_quo_next) : w_quo_next;
    assign w_rem_fix = r_rem_neg ? (-w_rem_next) : w_rem_next;

    assign busy      = (r_state != S_IDLE);
    assign stall_req = (w_accept & ~w_special) | (r_state == S_CALC);
    assign done      = r_done;
    assign result    = r_result;

    // Sequencer: accept, iterate, deliver; flush only aborts an active CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dsr     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_sel_rem <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel_rem <= op[1];
                        r_quo_neg <= w_dvd_neg ^ w_dsr_neg;
                        r_rem_neg <= w_dvd_neg;
                        r_quo     <= w_dvd_mag;
                        r_dsr     <= w_dsr_mag;
                        r_rem     <= '0;
                        if (w_special) begin
                            r_result <= w_spec_result;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_quo <= w_quo_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed and randomized checks of ex_div_unit against a
// plain-arithmetic RV32M divide model.

module tb_ex_div_unit;

    localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_result;

    ex_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic is_signed;
        logic want_rem;
        is_signed = ~o[0];
        want_rem  = o[1];
        if (b == 32'd0)
            return want_rem ? a : ALL_ONES;
        if (is_signed && a == MIN_NEG && b == ALL_ONES)
            return want_rem ? 32'd0 : MIN_NEG;
        if (is_signed) begin
            if (want_rem) return $signed(a) % $signed(b);
            return $signed(a) / $signed(b);
        end
        if (want_rem) return a % b;
        return a / b;
    endfunction

    // Issue one divide in the current (IDLE) cycle and follow it to its done pulse.
    // poke raises start for a few cycles while busy; it must be ignored.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input bit poke);
        bit special;
        int exp_lat;
        int lat;
        special = (b == 32'd0) || (!o[0] && a == MIN_NEG && b == ALL_ONES);
        exp_lat = special ? 1 : 33;
        op = o; dividend = a; divisor = b; start = 1'b1;
        #1;
        check({tag, "_stall_T"}, {31'd0, stall_req}, {31'd0, !special});
        tick();
        start = 1'b0;
        op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 16)
                check({tag, "_stall_mid"}, {30'd0, stall_req, busy}, 32'd3);
            start = poke && (lat >= 4) && (lat < 9);
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
        tick();
        check({tag, "_done_1cyc"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_held"}, result, exp_res);
        last_result = exp_res;
    endtask

    initial begin
        logic [1:0]  r_o;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
        dividend = 32'd0; divisor = 32'd0;
        tick(); tick();
        check("reset_outputs", {29'd0, busy, done, stall_req}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        tick();
        last_result = 32'd0;

        do_op("divu_100_7",   2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
        do_op("remu_100_7",   2'b11, 32'd100, 32'd7, 32'd2,  1'b1);
        do_op("div_m7_2",     2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        do_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_7_m2",     2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        do_op("div_by0",      2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
        do_op("remu_by0",     2'b11, 32'h1234, 32'd0, 32'h1234, 1'b0);
        do_op("rem_by0_neg",  2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1'b0);
        do_op("div_ovf",      2'b00, MIN_NEG, ALL_ONES, MIN_NEG, 1'b0);
        do_op("rem_ovf",      2'b10, MIN_NEG, ALL_ONES, 32'd0, 1'b0);
        do_op("divu_min_m1",  2'b01, MIN_NEG, ALL_ONES, 32'd0, 1'b0);
        do_op("divu_max_1",   2'b01, ALL_ONES, 32'd1, ALL_ONES, 1'b0);
        do_op("remu_max_max", 2'b11, ALL_ONES, ALL_ONES, 32'd0, 1'b0);

        // start and flush together in IDLE: request dropped
        op = 2'b01; dividend = 32'd50; divisor = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        check("startflush_stall", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        check("startflush_idle", {30'd0, busy, done}, 32'd0);
        tick();
        check("startflush_idle2", {30'd0, busy, done}, 32'd0);

        // flush during CALC at T+10
        op = 2'b01; dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (done) check("flush_early_done", {31'd0, done}, 32'd0);
            tick();
        end
        check("flush_busy_T10", {30'd0, busy, done}, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle_T11", {30'd0, busy, done}, 32'd0);
        check("flush_result_kept", result, last_result);
        do_op("after_flush", 2'b01, 32'd1000, 32'd9, 32'd111, 1'b0);

        // asynchronous reset at T+5
        op = 2'b01; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", {30'd0, busy, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        tick();
        check("rst_held_no_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        last_result = 32'd0;
        do_op("after_reset", 2'b01, 32'd77, 32'd5, 32'd15, 1'b0);

        // randomized operations with corner-biased operands
        for (int n = 0; n < 40; n++) begin
            r_o = 2'($urandom);
            case ($urandom_range(0, 5))
                0:       r_a = MIN_NEG;
                1:       r_a = 32'd0;
                2:       r_a = 32'($urandom_range(0, 300));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       r_b = 32'd0;
                1:       r_b = ALL_ONES;
                2:       r_b = 32'($urandom_range(1, 20));
                3:       r_b = -32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            do_op("rand", r_o, r_a, r_b, ref_div(r_o, r_a, r_b), n[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
